mem_access: RTL and testbench

Memory-stage responder for the RV32I pipeline. Consumes the 5-bit memory request, effective address and store data produced by the execute stage, and performs the access over an 8-bit single-port memory bus one byte per cycle. Loads return a sign- or zero-extended 32-bit result to write-back. While an access is in flight the block stalls the pipeline; non-memory instructions pass through in one cycle.

---
 rtl/mem_access.sv | 179 +++++++++++++++++
 tb/tb_mem_access.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: RV32I memory stage, byte-serial access over an 8-bit bus.
// Optional MEM_MISALIGN_CHECK_EN drops misaligned half/word requests.
module mem_access (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  e_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  wa_i,
  input  logic        we_i,
  output logic [4:0]  wa_o,
  output logic        we_o,
  output logic [31:0] wn_o,
  output logic        stall_o,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_wr,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    IDLE, RD, RWAIT, WR, DONE
  } state_t;

  state_t state, nxt;

  logic [1:0]  len;
  logic        zx;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  wa;
  logic        we;
  logic [1:0]  cnt;
  logic [23:0] lbuf;
  logic [1:0]  len_i;
  logic        bad;
  logic        sgn;
  logic [31:0] res;

  // length code 2 is illegal and behaves as a word
  assign len_i = (e_i[3:2] == 2'd2) ? 2'd3 : e_i[3:2];

`ifdef MEM_MISALIGN_CHECK_EN
  assign bad = ((len_i == 2'd1) && addr_i[0]) ||
               ((len_i == 2'd3) && (addr_i[1:0] != 2'd0));
`else
  assign bad = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (e_i[4]) begin
          unique case (1'b1)
            bad:     nxt = DONE;
            e_i[1]:  nxt = WR;
            default: nxt = RD;
          endcase
        end
      end
      RD:    if (cnt == len) nxt = RWAIT;
      RWAIT: nxt = DONE;
      WR:    if (cnt == len) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    sgn = ~zx & mem_din[7];
    unique case (len)
      2'd0:    res = {{24{sgn}}, mem_din};
      2'd1:    res = {{16{sgn}}, mem_din, lbuf[7:0]};
      default: res = {mem_din, lbuf};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len   <= 2'd0;
      zx    <= 1'b0;
      addr  <= 32'd0;
      wdata <= 32'd0;
      wa    <= 5'd0;
      we    <= 1'b0;
      cnt   <= 2'd0;
      lbuf  <= 24'd0;
      wa_o  <= 5'd0;
      we_o  <= 1'b0;
      wn_o  <= 32'd0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (e_i[4]) begin
            len   <= len_i;
            zx    <= e_i[0];
            addr  <= addr_i;
            wdata <= wdata_i;
            wa    <= wa_i;
            we    <= we_i;
            cnt   <= 2'd0;
            if (bad) begin
              we_o <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
              misalign_o <= 1'b1;
`endif
            end
          end else begin
            wa_o <= wa_i;
            we_o <= we_i;
            wn_o <= addr_i;
          end
        end
        RD: begin
          // byte addressed last cycle arrives now
          unique case (cnt)
            2'd1:    lbuf[7:0]   <= mem_din;
            2'd2:    lbuf[15:8]  <= mem_din;
            2'd3:    lbuf[23:16] <= mem_din;
            default: ;
          endcase
          cnt <= cnt + 2'd1;
        end
        RWAIT: begin
          wn_o <= res;
          wa_o <= wa;
          we_o <= we;
        end
        WR: begin
          cnt <= cnt + 2'd1;
          if (cnt == len) begin
            wn_o <= addr;
            wa_o <= wa;
            we_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    unique case (state)
      RD: mem_a = addr + {30'd0, cnt};
      WR: begin
        mem_a  = addr + {30'd0, cnt};
        mem_wr = 1'b1;
        unique case (cnt)
          2'd0:    mem_dout = wdata[7:0];
          2'd1:    mem_dout = wdata[15:8];
          2'd2:    mem_dout = wdata[23:16];
          default: mem_dout = wdata[31:24];
        endcase
      end
      default: ;
    endcase
    stall_o = rst_n &
      (((state != IDLE) && (state != DONE)) ||
       ((state == IDLE) && e_i[4]));
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a byte memory model.
// Inputs change 2 time units after the rising edge, outputs sampled at 3.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  e_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  wa_i;
  logic        we_i;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] wn_o;
  logic        stall_o;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_wr;
  logic        misalign_o;

  int ncmp = 0;
  int nfail = 0;
  int stalls;
  logic [31:0] ra [16];
  logic [7:0]  rd [16];
  logic        rw [16];
  logic [7:0]  mem [1024];

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .e_i(e_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wa_i(wa_i), .we_i(we_i), .wa_o(wa_o),
    .we_o(we_o), .wn_o(wn_o), .stall_o(stall_o), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_wr(mem_wr),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= mem[mem_a[9:0]];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // present one request and follow it until stall drops (DONE cycle)
  task automatic access(input logic [4:0] e, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] w,
                        input logic wen);
    cyc();
    e_i = e; addr_i = a; wdata_i = wd; wa_i = w; we_i = wen;
    #1;
    stalls = 0;
    for (int k = 0; k < 16; k++) begin ra[k] = 0; rd[k] = 0; rw[k] = 0; end
    while (stall_o) begin
      if (stalls >= 15) begin
        ncmp++;
        nfail++;
        $error("FAIL timeout: observed stall beyond %0d cycles", stalls);
        break;
      end
      ra[stalls] = mem_a;
      rd[stalls] = mem_dout;
      rw[stalls] = mem_wr;
      stalls++;
      cyc();
      #1;
    end
    e_i = 5'd0;
    #0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h80;
    mem[10'h202] = 8'h34; mem[10'h203] = 8'h92;
    mem[10'h300] = 8'h11; mem[10'h301] = 8'h22;
    mem[10'h302] = 8'h33; mem[10'h303] = 8'h44;
    mem[10'h304] = 8'h55;
    mem[10'h3FF] = 8'hAB; mem[10'h000] = 8'hCD;

    rst_n = 1'b0;
    e_i = 5'd0; addr_i = 32'd0; wdata_i = 32'd0; wa_i = 5'd0; we_i = 1'b0;
    #13;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_wn", wn_o, 32'd0);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    rst_n = 1'b1;

    // LB 0x100 -> sign-extended 0x80
    access(5'b10000, 32'h100, 32'd0, 5'd7, 1'b1);
    check("lb_stalls", stalls, 3);
    check("lb_idle_a", ra[0], 32'h0);
    check("lb_a", ra[1], 32'h100);
    check("lb_wr", {31'd0, rw[1]}, 32'd0);
    check("lb_wn", wn_o, 32'hFFFFFF80);
    check("lb_we", {31'd0, we_o}, 32'd1);
    check("lb_wa", {27'd0, wa_o}, 32'd7);

    // LBU 0x100
    access(5'b10001, 32'h100, 32'd0, 5'd8, 1'b1);
    check("lbu_wn", wn_o, 32'h00000080);

    // LHU / LH 0x202
    access(5'b10101, 32'h202, 32'd0, 5'd9, 1'b1);
    check("lhu_stalls", stalls, 4);
    check("lhu_a0", ra[1], 32'h202);
    check("lhu_a1", ra[2], 32'h203);
    check("lhu_wn", wn_o, 32'h00009234);
    access(5'b10100, 32'h202, 32'd0, 5'd9, 1'b1);
    check("lh_wn", wn_o, 32'hFFFF9234);

    // LW 0x300
    access(5'b11100, 32'h300, 32'd0, 5'd10, 1'b1);
    check("lw_stalls", stalls, 6);
    check("lw_a3", ra[4], 32'h303);
    check("lw_wn", wn_o, 32'h44332211);
    check("lw_wa", {27'd0, wa_o}, 32'd10);

    // illegal length code 2 behaves as word
    access(5'b11000, 32'h300, 32'd0, 5'd11, 1'b1);
    check("len2_stalls", stalls, 6);
    check("len2_wn", wn_o, 32'h44332211);

    // SW 0xDEADBEEF at 0x10
    access(5'b11110, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
    check("sw_stalls", stalls, 5);
    check("sw_idle_wr", {31'd0, rw[0]}, 32'd0);
    check("sw_wr0", {31'd0, rw[1]}, 32'd1);
    check("sw_wr3", {31'd0, rw[4]}, 32'd1);
    check("sw_a0", ra[1], 32'h10);
    check("sw_d0", {24'd0, rd[1]}, 32'hEF);
    check("sw_a1", ra[2], 32'h11);
    check("sw_d1", {24'd0, rd[2]}, 32'hBE);
    check("sw_a2", ra[3], 32'h12);
    check("sw_d2", {24'd0, rd[3]}, 32'hAD);
    check("sw_a3", ra[4], 32'h13);
    check("sw_d3", {24'd0, rd[4]}, 32'hDE);
    check("sw_we", {31'd0, we_o}, 32'd0);
    check("sw_wn", wn_o, 32'h10);
    check("sw_done_wr", {31'd0, mem_wr}, 32'd0);

    // SB 0x12345678 at 0x20
    access(5'b10010, 32'h20, 32'h12345678, 5'd0, 1'b0);
    check("sb_stalls", stalls, 2);
    check("sb_d", {24'd0, rd[1]}, 32'h78);

    // LHU wrapping past 0xFFFFFFFF
    access(5'b10101, 32'hFFFFFFFF, 32'd0, 5'd12, 1'b1);
    check("wrap_a0", ra[1], 32'hFFFFFFFF);
    check("wrap_a1", ra[2], 32'h0);
    check("wrap_wn", wn_o, 32'h0000CDAB);

    // misaligned LW 0x301
    access(5'b11100, 32'h301, 32'd0, 5'd13, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
    check("mis_stalls", stalls, 1);
    check("mis_wr", {31'd0, rw[0]}, 32'd0);
    check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    check("mis_we", {31'd0, we_o}, 32'd0);
`else
    check("mis_stalls", stalls, 6);
    check("mis_a0", ra[1], 32'h301);
    check("mis_a3", ra[4], 32'h304);
    check("mis_wn", wn_o, 32'h55443322);
    check("mis_pulse", {31'd0, misalign_o}, 32'd0);
`endif

    // pass-through ADD x5 = 0x55
    cyc();
    e_i = 5'd0; addr_i = 32'h55; wa_i = 5'd5; we_i = 1'b1;
    #1;
    check("pt_stall", {31'd0, stall_o}, 32'd0);
    cyc();
    #1;
    check("pt_wa", {27'd0, wa_o}, 32'd5);
    check("pt_we", {31'd0, we_o}, 32'd1);
    check("pt_wn", wn_o, 32'h55);

    // reset in the middle of a word load
    e_i = 5'b11100; addr_i = 32'h300; wa_i = 5'd14; we_i = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    check("mid_rst_mem_a", mem_a, 32'd0);
    check("mid_rst_wn", wn_o, 32'd0);
    check("mid_rst_we", {31'd0, we_o}, 32'd0);
    check("mid_rst_wa", {27'd0, wa_o}, 32'd0);
    e_i = 5'd0;
    cyc();
    rst_n = 1'b1;

    access(5'b10000, 32'h100, 32'd0, 5'd3, 1'b1);
    check("post_rst_stalls", stalls, 3);
    check("post_rst_a", ra[1], 32'h100);
    check("post_rst_wn", wn_o, 32'hFFFFFF80);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
